// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: dynamic branch predictor built on a pattern history
// table (PHT) of saturating counters, with saturating branch/mispredict stats.
// Compile-time option: define BRANCH_PREDICTOR_GSHARE_EN to index the PHT with
// PC XOR global history (gshare); leave it undefined for PC-only (bimodal) mode.
// Branch outcome encoding on the ports: TAKEN = 1'b1, NOT_TAKEN = 1'b0.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_predictor_gshare #(
  parameter int INDEX_BITS = 8,
  parameter int HIST_BITS  = 8,
  parameter int CTR_WIDTH  = 2,
  parameter int STAT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_valid,
  input  logic [`ADDR_WIDTH-1:0]   i_req_pc,
  input  logic [`ADDR_WIDTH-1:0]   i_req_target,
  output logic                     o_req_prediction,
  input  logic                     i_fb_valid,
  input  logic [`ADDR_WIDTH-1:0]   i_fb_pc,
  input  logic                     i_fb_prediction,
  input  logic                     i_fb_outcome,
  output logic                     o_ready,
  output logic [HIST_BITS-1:0]     o_ghr,
  output logic [STAT_WIDTH-1:0]    o_branch_count,
  output logic [STAT_WIDTH-1:0]    o_mispredict_count
);

  localparam int PHT_SIZE = 1 << INDEX_BITS;
  localparam logic TAKEN = 1'b1;
  localparam logic [CTR_WIDTH-1:0]  CTR_WNT  = {1'b0, {(CTR_WIDTH-1){1'b1}}};
  localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0]  CTR_MIN  = {CTR_WIDTH{1'b0}};
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
  localparam logic [INDEX_BITS-1:0] PTR_LAST = {INDEX_BITS{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   init_ptr_q, init_ptr_d;
  logic [STAT_WIDTH-1:0]   branch_cnt_q, branch_cnt_d;
  logic [STAT_WIDTH-1:0]   mispred_cnt_q, mispred_cnt_d;
  logic [CTR_WIDTH-1:0]    pht_q [PHT_SIZE];

  logic                    pht_we_s;
  logic [INDEX_BITS-1:0]   pht_waddr_s;
  logic [CTR_WIDTH-1:0]    pht_wdata_s;
  logic                    fb_upd_s;
  logic [HIST_BITS-1:0]    ghr_s;
  logic [INDEX_BITS-1:0]   req_idx_s;
  logic [INDEX_BITS-1:0]   fb_idx_s;
  logic                    unused_ok_s;

  // Saturating step of a PHT counter toward the resolved outcome.
  function automatic logic [CTR_WIDTH-1:0] ctr_next(input logic [CTR_WIDTH-1:0] ctr,
                                                     input logic             outcome);
    if (outcome == TAKEN) begin
      if (ctr == CTR_MAX) return ctr;
      else                return ctr + CTR_WIDTH'(1);
    end else begin
      if (ctr == CTR_MIN) return ctr;
      else                return ctr - CTR_WIDTH'(1);
    end
  endfunction

  // Saturating increment of a statistics counter.
  function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] v);
    if (v == STAT_MAX) return v;
    else               return v + STAT_WIDTH'(1);
  endfunction

  // Only PC bits [INDEX_BITS+1:2] matter; the rest of these inputs are kept
  // purely so the port list matches the predictors this block replaces.
  assign unused_ok_s = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc};

  // Request and feedback each hash their own PC with the current history.
  assign req_idx_s = i_req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_s);
  assign fb_idx_s  = i_fb_pc[INDEX_BITS+1:2]  ^ INDEX_BITS'(ghr_s);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  // Shift the resolved outcome into the history on each accepted feedback.
  always_comb begin
    ghr_d = ghr_q;
    if (fb_upd_s) begin
      ghr_d = HIST_BITS'({ghr_q, i_fb_outcome});
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Global history register; non-speculative, updated from execute only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= {HIST_BITS{1'b0}};
    else        ghr_q <= ghr_d;
  end

  assign ghr_s = ghr_q;
`else
  assign ghr_s = {HIST_BITS{1'b0}};
`endif

  // Init sweep / run control, PHT write port selection and statistics.
  always_comb begin
    state_d       = state_q;
    init_ptr_d    = init_ptr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    pht_we_s      = 1'b0;
    pht_waddr_s   = init_ptr_q;
    pht_wdata_s   = CTR_WNT;
    fb_upd_s      = 1'b0;
    case (state_q)
      ST_INIT: begin
        pht_we_s   = 1'b1;
        init_ptr_d = init_ptr_q + INDEX_BITS'(1);
        if (init_ptr_q == PTR_LAST) state_d = ST_RUN;
        else                        state_d = ST_INIT;
      end
      ST_RUN: begin
        if (i_fb_valid) begin
          fb_upd_s     = 1'b1;
          pht_we_s     = 1'b1;
          pht_waddr_s  = fb_idx_s;
          pht_wdata_s  = ctr_next(pht_q[fb_idx_s], i_fb_outcome);
          branch_cnt_d = stat_inc(branch_cnt_q);
          if (i_fb_prediction != i_fb_outcome) mispred_cnt_d = stat_inc(mispred_cnt_q);
          else                                 mispred_cnt_d = mispred_cnt_q;
        end else begin
          pht_we_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control state and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= {INDEX_BITS{1'b0}};
      branch_cnt_q  <= {STAT_WIDTH{1'b0}};
      mispred_cnt_q <= {STAT_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // PHT storage; contents are rebuilt by the init sweep, so no reset is needed.
  always_ff @(posedge clk) begin
    if (pht_we_s) pht_q[pht_waddr_s] <= pht_wdata_s;
  end

  // Prediction reads the pre-update counter; there is no feedback bypass.
  assign o_req_prediction   = (state_q == ST_RUN) ? pht_q[req_idx_s][CTR_WIDTH-1] : 1'b0;
  assign o_ready            = (state_q == ST_RUN);
  assign o_ghr              = ghr_s;
  assign o_branch_count     = branch_cnt_q;
  assign o_mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: directed bench for branch_predictor_gshare with a
// reference model and an expected-value queue. Works in both the bimodal build
// and with BRANCH_PREDICTOR_GSHARE_EN defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_predictor_gshare;

  localparam int AW = `ADDR_WIDTH;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid;
  logic [AW-1:0] i_req_pc;
  logic [AW-1:0] i_req_target;
  logic          o_req_prediction;
  logic          i_fb_valid;
  logic [AW-1:0] i_fb_pc;
  logic          i_fb_prediction;
  logic          i_fb_outcome;
  logic          o_ready;
  logic [3:0]    o_ghr;
  logic [3:0]    o_branch_count;
  logic [3:0]    o_mispredict_count;

  branch_predictor_gshare #(
    .INDEX_BITS(4), .HIST_BITS(4), .CTR_WIDTH(2), .STAT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_pc(i_req_pc), .i_req_target(i_req_target),
    .o_req_prediction(o_req_prediction),
    .i_fb_valid(i_fb_valid), .i_fb_pc(i_fb_pc), .i_fb_prediction(i_fb_prediction),
    .i_fb_outcome(i_fb_outcome),
    .o_ready(o_ready), .o_ghr(o_ghr),
    .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state.
  logic [1:0] pht_m [16];
  logic [3:0] ghr_m;
  int         bc_m, mc_m;
  bit         ready_m;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h with no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push(tag, exp);
    pop_check(obs);
  endtask

  function automatic logic [3:0] idx_m(input logic [AW-1:0] pc);
    logic [AW-1:0] p;
    p = pc;
    return p[5:2] ^ (GSHARE ? ghr_m : 4'd0);
  endfunction

  function automatic logic pred_m(input logic [AW-1:0] pc);
    logic [3:0] ix;
    ix = idx_m(pc);
    if (ready_m) return pht_m[ix][1];
    else         return 1'b0;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 16; k++) pht_m[k] = 2'b01;
    ghr_m   = 4'd0;
    bc_m    = 0;
    mc_m    = 0;
    ready_m = 1'b0;
  endtask

  // One resolved branch; the request port looks at the same PC in the same
  // cycle, so it must see the counter before this update.
  task automatic fb(input logic [AW-1:0] pc, input logic pred, input logic out);
    logic [3:0] ix;
    i_fb_valid      = 1'b1;
    i_fb_pc         = pc;
    i_fb_prediction = pred;
    i_fb_outcome    = out;
    i_req_pc        = pc;
    push("same_cycle_pred", {31'd0, pred_m(pc)});
    #1;
    pop_check({31'd0, o_req_prediction});
    @(posedge clk);
    #1;
    ix = idx_m(pc);
    if (out) pht_m[ix] = (pht_m[ix] == 2'b11) ? 2'b11 : pht_m[ix] + 2'd1;
    else     pht_m[ix] = (pht_m[ix] == 2'b00) ? 2'b00 : pht_m[ix] - 2'd1;
    if (GSHARE) ghr_m = {ghr_m[2:0], out};
    if (bc_m < 15) bc_m++;
    if (pred != out && mc_m < 15) mc_m++;
    i_fb_valid = 1'b0;
  endtask

  task automatic chk_pred(input string tag, input logic [AW-1:0] pc);
    i_req_pc = pc;
    push(tag, {31'd0, pred_m(pc)});
    #1;
    pop_check({31'd0, o_req_prediction});
  endtask

  task automatic sweep();
    for (int c = 0; c < 16; c++) begin
      push("ready_sweep", {31'd0, (c == 15)});
      @(posedge clk);
      #1;
      pop_check({31'd0, o_ready});
    end
    ready_m = 1'b1;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_ghr"}, o_ghr, ghr_m);
    chk({tag, "_branches"}, o_branch_count, bc_m);
    chk({tag, "_mispred"}, o_mispredict_count, mc_m);
  endtask

  initial begin
    rst_n = 1'b0;
    i_req_valid = 1'b1; i_req_pc = '0; i_req_target = '0;
    i_fb_valid = 1'b1; i_fb_pc = 32'h40; i_fb_prediction = 1'b0; i_fb_outcome = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 32'd0);
    chk("rst_pred", o_req_prediction, 32'd0);
    chk_stats("rst");

    // Release reset with feedback still asserted: INIT must ignore it.
    @(negedge clk);
    rst_n = 1'b1;
    sweep();
    i_fb_valid = 1'b0;
    chk_stats("init_fb_ignored");
    for (int i = 0; i < 16; i++) begin
      chk("pht_init", dut.pht_q[i], 32'd1);
      chk_pred("init_pred", 32'(i * 4));
    end

    // Same-cycle collision on a WNT counter, then the post-update value.
    fb(32'h08, 1'b0, 1'b1);
    chk_pred("collision_next", 32'h08);

    // Saturation at pc 0x40.
    for (int i = 0; i < 3; i++) begin
      fb(32'h40, 1'b0, 1'b1);
      chk_pred("sat_taken", 32'h40);
    end
    for (int i = 0; i < 5; i++) begin
      fb(32'h40, 1'b1, 1'b0);
      chk_pred("sat_not_taken", 32'h40);
    end
    chk("pht_sat_low", dut.pht_q[idx_m(32'h40)], pht_m[idx_m(32'h40)]);
    chk_stats("after_sat");

    // History T,T,N, then train the aliased entry for pc 0x18.
    fb(32'h100, 1'b0, 1'b1);
    fb(32'h100, 1'b0, 1'b1);
    fb(32'h100, 1'b1, 1'b0);
    chk("ghr_ttn", o_ghr, ghr_m);
    chk_pred("alias_before", 32'h18);
    fb(32'h18, 1'b0, 1'b1);
    chk_pred("alias_after", 32'h18);

    // Asynchronous reset mid-cycle: outputs clear without waiting for an edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("midrst_ready", o_ready, 32'd0);
    chk("midrst_pred", o_req_prediction, 32'd0);
    chk_stats("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    sweep();

    // Statistics: 10 branches, 3 mispredicted.
    for (int i = 0; i < 10; i++) begin
      fb(32'(i * 4), (i < 3) ? ~i[0] : i[0], i[0]);
    end
    chk_stats("stats_10");
    // Ten more (3 mispredicted): branch count saturates at 15.
    for (int i = 0; i < 10; i++) begin
      fb(32'(i * 8), (i < 3) ? i[0] : ~i[0], ~i[0]);
    end
    chk_stats("stats_sat");
    chk("stats_sat_const", o_branch_count, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
